// File: rtl/input_conditioner.sv
// N-channel conditioner for asynchronous board inputs: synchroniser, counter debouncer,
// registered edge pulses and maskable sticky event flags with a summary interrupt.
module input_conditioner #(
    parameter int unsigned     WIDTH           = 16,
    parameter int unsigned     SYNC_STAGES     = 2,
    parameter int unsigned     DEBOUNCE_CYCLES = 100000,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] event_clr,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] event_flags,
    output logic             irq
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_last;
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] flags_q, flags_d;

    assign sync_last = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= RESET_VALUE;
            end
        end else begin
            sync_q[0] <= din;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // A channel is accepted on the DEBOUNCE_CYCLES-th consecutive cycle that differs from dout.
    always_comb begin
        dout_d = dout_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_last[i] != dout_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    dout_d[i] = sync_last[i];
                    rise_d[i] = sync_last[i];
                    fall_d[i] = ~sync_last[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Flags are set from the visible pulses, so a clear coinciding with a pulse loses.
    always_comb begin
        flags_d = (flags_q & ~event_clr) | (rise_q & rise_en) | (fall_q & fall_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            dout_q  <= RESET_VALUE;
            rise_q  <= '0;
            fall_q  <= '0;
            flags_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            flags_q <= flags_d;
        end
    end

    assign dout        = dout_q;
    assign rise        = rise_q;
    assign fall        = fall_q;
    assign event_flags = flags_q;
    assign irq         = |flags_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Randomised and directed bench for input_conditioner against a behavioural model of the
// delay line, run-length debounce and sticky flag rules.
module tb_input_conditioner;

    localparam int unsigned W    = 4;
    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din, rise_en, fall_en, event_clr;
    logic [W-1:0] dout, rise, fall, event_flags;
    logic         irq;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [W-1:0] m_hist [SYNC];
    logic [W-1:0] m_dout, m_rise, m_fall, m_flags;
    int           m_run [W];

    input_conditioner #(
        .WIDTH          (W),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .RESET_VALUE    ('0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .rise_en    (rise_en),
        .fall_en    (fall_en),
        .event_clr  (event_clr),
        .dout       (dout),
        .rise       (rise),
        .fall       (fall),
        .event_flags(event_flags),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model update for one rising edge, using the inputs held across that edge.
    task automatic model_edge();
        logic [W-1:0] s;
        logic [W-1:0] nr, nf;
        if (rst) begin
            for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
            for (int c = 0; c < W; c++) m_run[c] = 0;
            m_dout = '0; m_rise = '0; m_fall = '0; m_flags = '0;
        end else begin
            s  = m_hist[SYNC-1];
            nr = '0;
            nf = '0;
            for (int c = 0; c < W; c++) begin
                if (s[c] != m_dout[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == DEB) begin
                        m_dout[c] = s[c];
                        if (s[c]) nr[c] = 1'b1;
                        else      nf[c] = 1'b1;
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_flags = (m_flags & ~event_clr) | (m_rise & rise_en) | (m_fall & fall_en);
            m_rise  = nr;
            m_fall  = nf;
            for (int k = SYNC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = din;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("dout",  32'(dout),        32'(m_dout));
        check("rise",  32'(rise),        32'(m_rise));
        check("fall",  32'(fall),        32'(m_fall));
        check("flags", 32'(event_flags), 32'(m_flags));
        check("irq",   32'(irq),         32'(m_flags != '0));
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset(input logic [W-1:0] d);
        rst = 1'b1; din = d; event_clr = '0;
        cycles(3);
        check("rst_dout",  32'(dout),        32'h0);
        check("rst_flags", 32'(event_flags), 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
        for (int c = 0; c < W; c++) m_run[c] = 0;
        m_dout = '0; m_rise = '0; m_fall = '0; m_flags = '0;
        rst = 1'b1; din = '0; rise_en = '1; fall_en = '1; event_clr = '0;
        #1;

        // 1: inputs already high at reset release
        do_reset(4'b1010);
        cycles(5);
        check("t1_dout_e5", 32'(dout), 32'h0);
        cycle();
        check("t1_dout_e6", 32'(dout), 32'ha);
        check("t1_rise",    32'(rise), 32'ha);
        cycle();
        check("t1_flags", 32'(event_flags), 32'ha);
        check("t1_irq",   32'(irq),         32'h1);

        // 2: glitch shorter than the debounce window
        do_reset(4'b0000);
        din = 4'b0001;
        cycles(3);
        din = 4'b0000;
        cycles(8);
        check("t2_flags", 32'(event_flags), 32'h0);

        // 3 + 4: clean step, clear racing with the pulse, then clear alone
        din = 4'b0001;
        cycles(5);
        check("t3_dout_e5", 32'(dout), 32'h0);
        cycle();
        check("t3_dout_e6", 32'(dout), 32'h1);
        check("t3_rise",    32'(rise), 32'h1);
        event_clr = 4'b0001;
        cycle();
        check("t4_set_wins", 32'(event_flags), 32'h1);
        cycle();
        check("t4_cleared", 32'(event_flags), 32'h0);
        check("t4_irq",     32'(irq),         32'h0);
        event_clr = '0;
        cycles(2);
        din = 4'b0000;
        cycles(5);
        cycle();
        check("t3_fall", 32'(fall), 32'h1);
        cycles(2);

        // 5: masked falling edge still pulses but raises no flag
        rise_en = '0; fall_en = 4'b1011; event_clr = '1;
        din = 4'b0100;
        cycles(8);
        event_clr = '0;
        din = 4'b0000;
        cycles(5);
        cycle();
        check("t5_fall", 32'(fall), 32'h4);
        cycles(3);
        check("t5_irq", 32'(irq), 32'h0);
        rise_en = '1; fall_en = '1;

        // 6: reset mid-count drops the pending change
        do_reset(4'b0000);
        din = 4'b0010;
        cycles(2);
        rst = 1'b1;
        cycle();
        check("t6_dout", 32'(dout), 32'h0);
        rst = 1'b0;
        cycles(5);
        check("t6_dout_e5", 32'(dout), 32'h0);
        cycle();
        check("t6_dout_e6", 32'(dout), 32'h2);

        // Random phase: slow-changing inputs so both glitches and accepted edges occur
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < W; c++) begin
                if ($urandom_range(7) == 0) din[c] = ~din[c];
            end
            if ($urandom_range(31) == 0) rise_en = W'($urandom);
            if ($urandom_range(31) == 0) fall_en = W'($urandom);
            event_clr = ($urandom_range(3) == 0) ? W'($urandom) : '0;
            rst = ($urandom_range(199) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
